divider_control: RTL and testbench

Sequencing controller for the 32-bit shift-subtract (restoring) divider in the ALU datapath. It accepts a start request, loads the Divisor and Remainder registers, and steps the ALU subtract/shift loop 32 times. It then issues the final remainder correction and reports completion or divide-by-zero. It holds no operand data; it only drives the register and ALU control strobes.

---
 rtl/divider_control.sv | 166 ++++++++++++++++
 tb/tb_divider_control.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_control.sv
// ---------------------------------------------------------------------------
// divider_control
//
// Sequencer for the 32-bit restoring (shift-subtract) divider. It loads the
// Divisor and Remainder registers, runs ITER subtract/shift steps, applies the
// final remainder correction and reports completion or divide-by-zero. No
// operand data passes through this block; it only drives control strobes.
//
// Handshake: start is a level request sampled only while idle (busy = 0).
// Once the request is accepted, busy stays high until the cycle after the
// one-cycle done pulse. start while busy is dropped, not queued. abort
// cancels any operation in progress on the next edge.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   start        division request (sampled in IDLE)
//   abort        cancel in-progress operation (ignored in IDLE)
//   divisor_zero datapath flag: Divisor register == 0 (valid from CHECK)
//   rem_msb      sign of ALU result (Remainder_hi - Divisor), this cycle
//   div_wrctrl   write Divisor register
//   div_clr      clear Divisor register
//   rem_load     load Remainder with {32'b0, dividend}
//   rem_clr      clear Remainder register
//   rem_wrhi     write ALU result into Remainder[63:32] before the shift
//   rem_shl      shift Remainder left by 1
//   shift_in     bit shifted into Remainder[0]
//   rem_shr_hi   shift Remainder[63:32] right by 1 (final correction)
//   alu_sub      ALU subtract select
//   busy         high in every state except IDLE
//   done         one-cycle completion pulse
//   dbz          divide-by-zero flag, sticky until next accepted start
// ---------------------------------------------------------------------------
module divider_control #(
    parameter int ITER = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic abort,
    input  logic divisor_zero,
    input  logic rem_msb,
    output logic div_wrctrl,
    output logic div_clr,
    output logic rem_load,
    output logic rem_clr,
    output logic rem_wrhi,
    output logic rem_shl,
    output logic shift_in,
    output logic rem_shr_hi,
    output logic alu_sub,
    output logic busy,
    output logic done,
    output logic dbz
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_CHECK  = 3'd2,
        S_SHIFT0 = 3'd3,
        S_ITER   = 3'd4,
        S_FIX    = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    localparam logic [4:0] LAST = 5'(ITER - 1);

    state_t     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic       dbz_q, dbz_d;

    // Next-state logic. abort outranks every other transition but never
    // touches dbz.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
        if (state_q != S_IDLE && abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_LOAD;
                        cnt_d   = '0;
                        dbz_d   = 1'b0;
                    end
                end
                S_LOAD:   state_d = S_CHECK;
                S_CHECK: begin
                    if (divisor_zero) begin
                        state_d = S_DONE;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = S_SHIFT0;
                    end
                end
                S_SHIFT0: state_d = S_ITER;
                S_ITER: begin
                    // Hold the counter on the last step so it never wraps.
                    if (cnt_q == LAST) begin
                        state_d = S_FIX;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                S_FIX:    state_d = S_DONE;
                S_DONE:   state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

    // Strobes decode from the current state. In ITER they also depend on
    // rem_msb within the same cycle: a non-negative difference is written
    // back and a 1 enters the quotient.
    always_comb begin
        div_wrctrl = 1'b0;
        div_clr    = 1'b0;
        rem_load   = 1'b0;
        rem_clr    = 1'b0;
        rem_wrhi   = 1'b0;
        rem_shl    = 1'b0;
        shift_in   = 1'b0;
        rem_shr_hi = 1'b0;
        alu_sub    = 1'b0;
        done       = 1'b0;
        busy       = (state_q != S_IDLE);
        dbz        = dbz_q;
        case (state_q)
            S_LOAD: begin
                div_wrctrl = 1'b1;
                rem_load   = 1'b1;
            end
            S_SHIFT0: rem_shl = 1'b1;
            S_ITER: begin
                alu_sub  = 1'b1;
                rem_shl  = 1'b1;
                rem_wrhi = ~rem_msb;
                shift_in = ~rem_msb;
            end
            S_FIX:   rem_shr_hi = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
        // Abort clears the datapath registers in the same cycle it is seen.
        if (state_q != S_IDLE && abort) begin
            div_clr = 1'b1;
            rem_clr = 1'b1;
        end
    end

endmodule

// File: tb/tb_divider_control.sv
module tb_divider_control;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic divisor_zero;
  logic rem_msb;
  logic div_wrctrl, div_clr, rem_load, rem_clr, rem_wrhi, rem_shl;
  logic shift_in, rem_shr_hi, alu_sub, busy, done, dbz;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  divider_control #(.ITER(32)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .divisor_zero(divisor_zero), .rem_msb(rem_msb),
    .div_wrctrl(div_wrctrl), .div_clr(div_clr), .rem_load(rem_load),
    .rem_clr(rem_clr), .rem_wrhi(rem_wrhi), .rem_shl(rem_shl),
    .shift_in(shift_in), .rem_shr_hi(rem_shr_hi), .alu_sub(alu_sub),
    .busy(busy), .done(done), .dbz(dbz)
  );

  logic [11:0] dut_vec;
  assign dut_vec = {div_wrctrl, div_clr, rem_load, rem_clr, rem_wrhi, rem_shl,
                    shift_in, rem_shr_hi, alu_sub, busy, done, dbz};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural datapath ----------------
  logic [31:0] dividend = 32'd0;
  logic [31:0] divisor_in = 32'd0;
  logic [63:0] dp_rem = 64'd0;
  logic [31:0] dp_div = 32'd0;
  logic [31:0] dp_diff;
  logic        msb_ovr = 1'b0;
  logic        msb_val = 1'b0;
  logic [11:0] s_out = 12'd0;

  assign dp_diff = dp_rem[63:32] - dp_div;
  assign rem_msb = msb_ovr ? msb_val : dp_diff[31];
  assign divisor_zero = (dp_div == 32'd0);

  always @(negedge clk) s_out <= dut_vec;

  always @(posedge clk) begin : datapath
    logic [63:0] r;
    r = dp_rem;
    if (s_out[7]) r[63:32] = dp_diff;                       // rem_wrhi
    if (s_out[6]) r = {r[62:0], s_out[5]};                  // rem_shl, shift_in
    if (s_out[4]) r[63:32] = {1'b0, r[63:33]};              // rem_shr_hi
    if (s_out[9]) r = {32'd0, dividend};                    // rem_load
    if (s_out[8]) r = 64'd0;                                // rem_clr
    dp_rem <= r;
    if (s_out[11]) dp_div <= divisor_in;                    // div_wrctrl
    else if (s_out[10]) dp_div <= 32'd0;                    // div_clr
  end

  // ---------------- timeline reference model ----------------
  // m_t is the cycle number within the current operation (0 = idle):
  // 1 load, 2 check, 3 first shift (or done on divide-by-zero),
  // 4..35 the 32 iterations, 36 correction, 37 done.
  int   m_t = 0;
  logic m_zero = 1'b0;
  logic m_dbz = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_t   <= 0;
      m_dbz <= 1'b0;
    end else if (m_t == 0) begin
      if (start) begin
        m_t    <= 1;
        m_dbz  <= 1'b0;
        m_zero <= 1'b0;
      end
    end else if (abort) begin
      m_t <= 0;
    end else if (m_t == 2) begin
      if (divisor_zero) begin
        m_zero <= 1'b1;
        m_dbz  <= 1'b1;
      end
      m_t <= 3;
    end else if (m_t == 37 || (m_t == 3 && m_zero)) begin
      m_t <= 0;
    end else begin
      m_t <= m_t + 1;
    end
  end

  function automatic logic [11:0] model_out(input int t, input logic zp, input logic d,
                                            input logic ab, input logic msb);
    logic wr, clr, ld, wrhi, shl, si, shr, sub, bsy, dn;
    wr = 0; ld = 0; wrhi = 0; shl = 0; si = 0; shr = 0; sub = 0; dn = 0;
    bsy = (t != 0);
    clr = bsy && ab;
    if (t == 1) begin wr = 1; ld = 1; end
    if (t == 3) begin if (zp) dn = 1; else shl = 1; end
    if (t >= 4 && t <= 35) begin sub = 1; shl = 1; wrhi = ~msb; si = ~msb; end
    if (t == 36) shr = 1;
    if (t == 37) dn = 1;
    return {wr, clr, ld, clr, wrhi, shl, si, shr, sub, bsy, dn, d};
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("cycle_outputs", {52'd0, dut_vec},
          {52'd0, model_out(m_t, m_zero, m_dbz, abort, rem_msb)});
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise start in an idle cycle; on return the bench sits in cycle 1.
  task automatic start_op(input logic [31:0] dvd, input logic [31:0] dvs);
    dividend   = dvd;
    divisor_in = dvs;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  int nsub, ndone, done_cyc;
  logic busy38, wr39, clr10, busy11, dbz3;
  logic [5:0] wr_bits, si_bits;

  initial begin
    #2 rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", {52'd0, dut_vec}, 64'd0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // Normal run 100 / 7, with a stray start pulse in cycle 5.
    start_op(32'd100, 32'd7);
    nsub = 0; ndone = 0; done_cyc = 0;
    for (int c = 1; c <= 40; c++) begin
      start = (c == 5);
      @(negedge clk);
      if (done) begin ndone++; done_cyc = c; end
      if (alu_sub) nsub++;
      tick();
    end
    start = 1'b0;
    check("norm_done_cycle", done_cyc, 37);
    check("norm_done_count", ndone, 1);
    check("norm_sub_cycles", nsub, 32);
    check("norm_quotient", dp_rem[31:0], 32'd14);
    check("norm_remainder", dp_rem[63:32], 32'd2);

    // start held high: second operation accepted in cycle 38.
    dividend = 32'd50; divisor_in = 32'd3;
    start = 1'b1;
    tick();
    done_cyc = 0; busy38 = 1'b1; wr39 = 1'b0;
    for (int c = 1; c <= 42; c++) begin
      @(negedge clk);
      if (done && done_cyc == 0) done_cyc = c;
      if (c == 38) busy38 = busy;
      if (c == 39) wr39 = div_wrctrl;
      tick();
    end
    start = 1'b0;
    check("b2b_done_cycle", done_cyc, 37);
    check("b2b_idle_gap", busy38, 1'b0);
    check("b2b_second_load", wr39, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();

    // Divide by zero.
    start_op(32'd5, 32'd0);
    nsub = 0; done_cyc = 0; dbz3 = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (done) done_cyc = c;
      if (c == 3) dbz3 = dbz;
      if (alu_sub) nsub++;
      tick();
    end
    check("dbz_done_cycle", done_cyc, 3);
    check("dbz_flag_cycle3", dbz3, 1'b1);
    check("dbz_no_iter", nsub, 0);
    tick(); tick();
    @(negedge clk);
    check("dbz_sticky", dbz, 1'b1);
    tick();
    start_op(32'd9, 32'd7);
    @(negedge clk);
    check("dbz_cleared_on_start", dbz, 1'b0);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();

    // Abort in cycle 10.
    start_op(32'd100, 32'd7);
    ndone = 0; clr10 = 1'b0; busy11 = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      abort = (c == 10);
      @(negedge clk);
      if (c == 10) clr10 = div_clr && rem_clr;
      if (c == 11) busy11 = busy;
      if (done) ndone++;
      tick();
    end
    abort = 1'b0;
    check("abort_clear_strobes", clr10, 1'b1);
    check("abort_idle_next", busy11, 1'b0);
    check("abort_no_done", ndone, 0);

    // Mealy: rem_msb forced high in ITER cycles 4, 6, 8.
    start_op(32'd100, 32'd7);
    wr_bits = '0; si_bits = '0;
    for (int c = 1; c <= 38; c++) begin
      msb_ovr = 1'b1;
      msb_val = (c == 4 || c == 6 || c == 8);
      @(negedge clk);
      if (c >= 4 && c <= 9) begin
        wr_bits[c-4] = rem_wrhi;
        si_bits[c-4] = shift_in;
      end
      tick();
    end
    msb_ovr = 1'b0;
    check("mealy_wrhi", wr_bits, 6'b101010);
    check("mealy_shift_in", si_bits, 6'b101010);
    tick();

    // Reset asserted mid-ITER.
    start_op(32'd100, 32'd7);
    for (int c = 1; c < 20; c++) tick();
    #2 rst = 1'b0;
    #1;
    check("reset_mid_iter", {52'd0, dut_vec}, 64'd0);
    tick(); tick();
    rst = 1'b1;
    tick();
    start_op(32'd100, 32'd7);
    @(negedge clk);
    check("post_reset_load", {div_wrctrl, busy}, 2'b11);
    ndone = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (done) ndone++;
    end
    check("post_reset_done", ndone, 1);
    check("post_reset_quotient", dp_rem[31:0], 32'd14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
